// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller and its users in the pipeline.
// Holds the FSM encoding, default timing and address base, and the address-to-word mapping.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          SRAM_WAIT_DEF = 1;
    localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
    localparam int          CNT_W         = 4;

    // Word index of a CPU byte address; the subtraction wraps at 32 bits.
    function automatic logic [16:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] phys;
        phys = addr - base;
        return phys[18:2];
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Cycle counter for one half-word phase; tc is high on the phase's final cycle.
// Zero latency on tc. Clear has priority over count.
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int LIMIT = SRAM_WAIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count,
    output logic [CNT_W-1:0] value,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (count) begin
            value <= value + 1'b1;
        end
    end

    assign tc = (value == LIM);

endmodule

// File: rtl/sram_controller.sv
// 32-bit CPU load/store to a 16-bit asynchronous SRAM as two half-word phases.
// Access takes 2*(SRAM_WAIT+1)+1 cycles; ready stays low to freeze the pipeline meanwhile.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          SRAM_WAIT = SRAM_WAIT_DEF,
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [CNT_W-1:0] WAIT_M1 = CNT_W'(SRAM_WAIT - 1);

    state_t           state;
    logic             is_wr;
    logic [16:0]      idx;
    logic [31:0]      wdata;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             pre_last;
    logic             req;
    logic             dq_oe;
    logic [15:0]      dq_out;
    logic             cnt_clear;
    logic             cnt_count;

    assign req       = rd_en | wr_en;
    assign pre_last  = (cnt == WAIT_M1);
    assign cnt_clear = (state == ST_IDLE) || (state == ST_DONE) || tc;
    assign cnt_count = (state == ST_LO) || (state == ST_HI);

    sram_wait_counter #(
        .LIMIT (SRAM_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .count (cnt_count),
        .value (cnt),
        .tc    (tc)
    );

    // Strobe and bus are registered, so each is set one cycle ahead: the strobe
    // rises on the cycle before the phase ends, keeping the address stable under it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            is_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_LO;
                        is_wr     <= wr_en;
                        idx       <= word_idx(address, ADDR_BASE);
                        wdata     <= write_data;
                        SRAM_ADDR <= {word_idx(address, ADDR_BASE), 1'b0};
                        SRAM_WE_N <= ~wr_en;
                        dq_oe     <= wr_en;
                        dq_out    <= write_data[15:0];
                    end
                end
                ST_LO: begin
                    if (tc) begin
                        state     <= ST_HI;
                        SRAM_ADDR <= {idx, 1'b1};
                        SRAM_WE_N <= ~is_wr;
                        dq_out    <= wdata[31:16];
                        if (!is_wr) read_data[15:0] <= SRAM_DQ;
                    end else if (pre_last) begin
                        SRAM_WE_N <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (tc) begin
                        state     <= ST_DONE;
                        SRAM_ADDR <= '0;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!is_wr) read_data[31:16] <= SRAM_DQ;
                    end else if (pre_last) begin
                        SRAM_WE_N <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = ((state == ST_IDLE) && !req) || (state == ST_DONE);
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM half-word model, word-level reference memory, random traffic.
// A second instance with SRAM_WAIT=3 covers back-to-back reads with the request held high.
module tb_sram_controller;

    localparam int          W    = 1;
    localparam int          W3   = 3;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [17:0] sram_addr;
    wire  [15:0] dq;
    wire         we_n, ub_n, lb_n, ce_n, oe_n;

    logic        sram_drive;
    logic [15:0] smem [0:262143];

    assign dq = sram_drive ? smem[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!we_n) smem[sram_addr] <= dq;

    sram_controller #(.SRAM_WAIT(W), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(dq), .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    logic        rd3;
    logic        wr3 = 1'b0;
    logic [31:0] address3;
    logic [31:0] write_data3 = 32'h0;
    wire  [31:0] read_data3;
    wire         ready3;
    wire  [17:0] sram_addr3;
    wire  [15:0] dq3;
    wire         we_n3;
    wire  [3:0]  tie3;

    // ROM-like SRAM for the read-only instance: content is a function of the address.
    function automatic logic [15:0] rom(input logic [17:0] h);
        return h[15:0] ^ 16'hA5A5;
    endfunction

    assign dq3 = we_n3 ? rom(sram_addr3) : 16'hzzzz;

    sram_controller #(.SRAM_WAIT(W3), .ADDR_BASE(BASE)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3),
        .address(address3), .write_data(write_data3), .read_data(read_data3), .ready(ready3),
        .SRAM_ADDR(sram_addr3), .SRAM_DQ(dq3), .SRAM_WE_N(we_n3),
        .SRAM_UB_N(tie3[3]), .SRAM_LB_N(tie3[2]), .SRAM_CE_N(tie3[1]), .SRAM_OE_N(tie3[0])
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access, entered and left at posedge+1 with the controller idle.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        logic [16:0] ix;
        ix = 17'((a - BASE) >> 2);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        sram_drive = !wr;
        #1 chk("ready_req", 32'(ready), 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
        for (int k = 0; k < 2 * (W + 1); k++) begin
            int ph;
            bit last;
            ph   = k / (W + 1);
            last = (k % (W + 1)) == W;
            chk("ready_busy", 32'(ready), 32'd0);
            chk("addr", 32'(sram_addr), 32'({ix, ph[0]}));
            chk("we_n", 32'(we_n), 32'(!wr || last));
            if (wr) chk("dq_wr", 32'(dq), 32'((ph == 0) ? d[15:0] : d[31:16]));
            @(posedge clk); #1;
        end
        if (wr) ref_mem[int'(ix)] = d;
        else    exp_rd = ref_mem.exists(int'(ix)) ? ref_mem[int'(ix)] : 32'h0;
        chk("ready_done", 32'(ready), 32'd1);
        chk("rdata", read_data, exp_rd);
        sram_drive = 1'b0;
        @(posedge clk); #1;
        chk("idle_addr", 32'(sram_addr), 32'd0);
        chk("idle_we", 32'(we_n), 32'd1);
        chk("ready_idle", 32'(ready), 32'd1);
    endtask

    initial begin
        logic [16:0] ix;
        logic [16:0] idx3 [0:3];
        logic [31:0] a;
        int          op;

        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        rd3 = 1'b0; address3 = '0;
        sram_drive = 1'b0; exp_rd = 32'h0;
        for (int i = 0; i < 262144; i++) smem[i] <= 16'h0;

        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we", 32'(we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("ties", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
        chk("ties3", 32'(tie3), 32'd0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 1'b0, BASE, 32'hDEADBEEF);
        access(1'b0, 1'b1, BASE, 32'h0);
        access(1'b1, 1'b0, BASE + 32'h7FFFC, 32'hCAFEF00D);
        access(1'b0, 1'b1, BASE + 32'h7FFFC, 32'h0);
        access(1'b1, 1'b0, 32'd1023, 32'h0BADF00D);
        access(1'b0, 1'b1, BASE + 32'h7FFFE, 32'h0);
        access(1'b1, 1'b1, BASE + 32'd4, 32'h12345678);
        access(1'b0, 1'b1, BASE + 32'd4, 32'h0);

        for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 2));
            ix = ($urandom_range(0, 4) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 7));
            a  = BASE + {13'h0, ix, 2'b00} + 32'($urandom_range(0, 3));
            access(op != 0, op != 1, a, $urandom);
        end

        // Reset in the second LO cycle of a write aborts it.
        wr_en = 1'b1; address = BASE + 32'd12; write_data = $urandom;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("abort_we", 32'(we_n), 32'd1);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_rdata", read_data, 32'd0);
        exp_rd = 32'h0;
        ref_mem.delete(3);
        @(posedge clk); #1;
        chk("abort_quiet", 32'(we_n), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, BASE + 32'd4, 32'h0);

        // Back-to-back reads, request held high: 10-cycle period IDLE, 4xLO, 4xHI, DONE.
        idx3[0] = 17'h00005; idx3[1] = 17'h1FFFF; idx3[2] = 17'h000A3; idx3[3] = 17'h0;
        rd3 = 1'b1; address3 = BASE + {13'h0, idx3[0], 2'b00};
        for (int t = 0; t < 30; t++) begin
            int p;
            int acc;
            logic [17:0] exp_a;
            p   = t % 10;
            acc = t / 10;
            #1;
            if (p == 0 || p == 9) exp_a = 18'h0;
            else                  exp_a = {idx3[acc], p >= 5};
            chk("b2b_ready", 32'(ready3), 32'(p == 9));
            chk("b2b_addr", 32'(sram_addr3), 32'(exp_a));
            if (p == 9) begin
                chk("b2b_rdata", read_data3, {rom({idx3[acc], 1'b1}), rom({idx3[acc], 1'b0})});
                address3 = BASE + {13'h0, idx3[acc + 1], 2'b00};
            end
            if (p == 1) address3 = $urandom;
            @(posedge clk); #1;
        end
        rd3 = 1'b0;
        #1 chk("b2b_idle_addr", 32'(sram_addr3), 32'd0);
        @(posedge clk); #1;
        chk("b2b_end_ready", 32'(ready3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter SRAM_WAIT, default 1, wait cycles per half-word phase; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BASE, default 1024, byte offset subtracted from the CPU address before mapping.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wr_en, rd_en  in  1 each  memory-stage write and read requests.
REQ-006 SHALL have port address  in  32  byte address of the word.
REQ-007 SHALL have port write_data  in  32  store data.
REQ-008 SHALL have port read_data  out  32  load result.
REQ-009 SHALL have port ready  out  1  low while an access is in flight; pipeline freeze is ~ready.
REQ-010 SHALL have port SRAM_ADDR  out  18  half-word address.
REQ-011 SHALL have port SRAM_DQ  inout  16  bidirectional data.
REQ-012 SHALL have port SRAM_WE_N  out  1  active-low write strobe.
REQ-013 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied to 0.

Function
REQ-014 Address mapping SHALL be phys = address - ADDR_BASE (32-bit wrap); idx = phys[18:2]; low half at {idx,1'b0}, high half at {idx,1'b1}; phys[1:0] ignored.
REQ-015 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-016 IDLE -> LO when rd_en|wr_en is sampled high; otherwise stays IDLE.
REQ-017 The access type and the address/data SHALL be latched on IDLE -> LO; later input changes SHALL be ignored until IDLE.
REQ-018 LO and HI SHALL each last SRAM_WAIT+1 cycles, timed by a counter cleared on every state entry.
REQ-019 LO -> HI and HI -> DONE SHALL occur when counter == SRAM_WAIT; DONE -> IDLE unconditionally after one cycle.
REQ-020 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
REQ-021 Access latency SHALL be 2*(SRAM_WAIT+1)+1 cycles from request sample to the DONE cycle; default 5.
REQ-022 Writes: SRAM_DQ SHALL drive write_data[15:0] in LO and [31:16] in HI; Z in every other state.
REQ-023 Writes: SRAM_WE_N SHALL be 0 in all but the final cycle of each phase and 1 on the final cycle, so the address never changes while the strobe is low.
REQ-024 Reads: SRAM_DQ SHALL be Z and SRAM_WE_N SHALL be 1; SRAM_DQ SHALL be captured into read_data[15:0] on the final LO cycle and into read_data[31:16] on the final HI cycle.
REQ-025 read_data SHALL hold its value until the next read's capture; writes SHALL leave it unchanged.
REQ-026 rd_en and wr_en high together SHALL be treated as a write.
REQ-027 In IDLE, SRAM_ADDR SHALL be 0, SRAM_WE_N 1 and SRAM_DQ Z.
REQ-028 A request held high through DONE SHALL NOT start a second access; a new access SHALL start only from IDLE.

Reset
REQ-029 Assertion of rst SHALL, asynchronously, set state IDLE, counter 0, read_data 0, SRAM_WE_N 1, SRAM_DQ Z and SRAM_ADDR 0.
REQ-030 Reset mid-access SHALL abort the access with no further SRAM strobes; a partially written word is permitted.
REQ-031 ready SHALL evaluate to 1 during reset when no request is present.

Structure
REQ-032 State encodings and default SRAM_WAIT and ADDR_BASE values SHALL reside in the shared package used by the pipeline stages.
REQ-033 The half-phase wait counter SHALL be a sub-module, sram_wait_counter, with clear, count and terminal-count outputs.
REQ-034 The block SHALL instantiate no SRAM model; the bench SHALL provide one.

Verification
REQ-035 Write 0xDEADBEEF at address 1024, SRAM_WAIT=1: SRAM_ADDR 0 then 1; DQ 0xBEEF then 0xDEAD; WE_N 0,1,0,1; ready low 4 cycles, high in cycle 5.
REQ-036 Read back address 1024: read_data = 0xDEADBEEF in DONE; DQ never driven by the controller.
REQ-037 Address 1024+4*0x1FFFF: SRAM_ADDR 0x3FFFE then 0x3FFFF; address 1023 wraps to idx 0x1FFFF.
REQ-038 rd_en=wr_en=1 with write_data 0x12345678: behaves as write; read_data unchanged.
REQ-039 rst low in the second LO cycle of a write: same edge gives IDLE, WE_N=1, DQ Z; after release, a new read completes normally.
REQ-040 SRAM_WAIT=3, back-to-back reads with rd_en held high: each access 9 cycles; exactly one IDLE cycle between accesses; no duplicate access in DONE.
